pio_responder: RTL and testbench

PIO_RESPONDER -- requirements
Module: pio_responder

---
 rtl/pio_pkg.sv | 17 +
 rtl/pio_responder_if.sv | 13 +
 rtl/pio_debounce.sv | 34 +++
 rtl/pio_responder.sv | 59 +++++
 tb/tb_pio_responder.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pio_pkg.sv
// pio_pkg: register addresses and register-index enum shared by the PIO responder.
package pio_pkg;
  typedef enum logic [2:0] {
    REG_SW_DATA  = 3'd0,
    REG_LED_DATA = 3'd1,
    REG_IRQ_MASK = 3'd2,
    REG_EDGE_CAP = 3'd3,
    REG_LED_SET  = 3'd4,
    REG_LED_CLR  = 3'd5
  } reg_idx_e;
  localparam logic [2:0] ADDR_SW_DATA  = 3'd0;
  localparam logic [2:0] ADDR_LED_DATA = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_LED_SET  = 3'd4;
  localparam logic [2:0] ADDR_LED_CLR  = 3'd5;
endpackage

// File: rtl/pio_responder_if.sv
// pio_responder_if: never-stalling Avalon-MM slave bus with fixed read latency of one cycle.
interface pio_responder_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  modport master(output avs_address, avs_read, avs_write, avs_writedata,
                 input avs_readdata, avs_readdatavalid);
  modport slave(input avs_address, avs_read, avs_write, avs_writedata,
                output avs_readdata, avs_readdatavalid);
endinterface

// File: rtl/pio_debounce.sv
// pio_debounce: 2-flop synchroniser plus tick-sampled stable-compare debouncer.
module pio_debounce #(
  parameter int WIDTH = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] switch_in,
  output logic [WIDTH-1:0] debounced
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [WIDTH-1:0] sync1, sync2, prev, same;
  logic [CW-1:0]    cnt;
  logic             tick;
  assign tick = cnt == CW'(DEBOUNCE_CYCLES - 1);
  assign same = ~(sync2 ^ prev);
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1     <= '0;
      sync2     <= '0;
      prev      <= '0;
      cnt       <= '0;
      debounced <= '0;
    end else begin
      sync1 <= switch_in;
      sync2 <= sync1;
      cnt   <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        prev      <= sync2;
        debounced <= (debounced & ~same) | (sync2 & same);
      end
    end
  end
endmodule

// File: rtl/pio_responder.sv
// pio_responder: switch/LED PIO with debounced inputs, rising-edge capture and level irq.
module pio_responder
  import pio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  pio_responder_if.slave   avs,
  output logic             irq,
  input  logic [WIDTH-1:0] switch_in,
  output logic [WIDTH-1:0] led_out
);
  logic [WIDTH-1:0] sw_data, sw_q, led_data, led_next, irq_mask, edge_cap, wd, rise, rdata, w1c;
  logic             wr_led, wr_mask, wr_ecap, wr_set, wr_clr;
  pio_debounce #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .switch_in    (switch_in),
    .debounced    (sw_data)
  );
  assign wd      = avs.avs_writedata[WIDTH-1:0];
  assign wr_led  = avs.avs_write && avs.avs_address == ADDR_LED_DATA;
  assign wr_mask = avs.avs_write && avs.avs_address == ADDR_IRQ_MASK;
  assign wr_ecap = avs.avs_write && avs.avs_address == ADDR_EDGE_CAP;
  assign wr_set  = avs.avs_write && avs.avs_address == ADDR_LED_SET;
  assign wr_clr  = avs.avs_write && avs.avs_address == ADDR_LED_CLR;
  assign rise    = sw_data & ~sw_q;
  assign w1c     = wr_ecap ? wd : '0;
  assign led_out = led_data;
  always_comb begin
    rdata = avs.avs_address == ADDR_SW_DATA  ? sw_data  :
            avs.avs_address == ADDR_LED_DATA ? led_data :
            avs.avs_address == ADDR_IRQ_MASK ? irq_mask :
            avs.avs_address == ADDR_EDGE_CAP ? edge_cap : '0;
    led_next = wr_led ? wd : wr_set ? led_data | wd : wr_clr ? led_data & ~wd : led_data;
  end
  // A fresh rising edge wins over a simultaneous write-1-clear of the same bit.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sw_q                  <= '0;
      led_data              <= '0;
      irq_mask              <= '0;
      edge_cap              <= '0;
      irq                   <= 1'b0;
      avs.avs_readdata      <= '0;
      avs.avs_readdatavalid <= 1'b0;
    end else begin
      sw_q                  <= sw_data;
      led_data              <= led_next;
      irq_mask              <= wr_mask ? wd : irq_mask;
      edge_cap              <= (edge_cap & ~w1c) | rise;
      irq                   <= |(edge_cap & irq_mask);
      avs.avs_readdata      <= avs.avs_read ? 32'(rdata) : '0;
      avs.avs_readdatavalid <= avs.avs_read;
    end
  end
endmodule

// File: tb/tb_pio_responder.sv
// tb_pio_responder: table vectors, directed corner cases and random traffic vs a behavioural model.
module tb_pio_responder;
  localparam int N = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       irq;
  logic [7:0] switch_in = '0;
  logic [7:0] led_out;
  int         errors = 0;
  int         checks = 0;
  pio_responder_if bus();
  pio_responder #(.WIDTH(8), .DEBOUNCE_CYCLES(N)) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .avs          (bus),
    .irq          (irq),
    .switch_in    (switch_in),
    .led_out      (led_out)
  );
  always #5 clk = ~clk;

  // behavioural model: registers, debounced state sampled every N clocks after release
  logic [7:0]  m_sw = '0, m_led = '0, m_mask = '0, m_ecap = '0, m_prev = '0, m_rise = '0;
  logic [7:0]  h0 = '0, h1 = '0, samp, nsw, wdm, clr;
  logic [31:0] m_rd = '0;
  logic        m_rdv = 1'b0, m_irq = 1'b0;
  int unsigned m_k = 0;

  function automatic logic [7:0] reg_val(input logic [2:0] a);
    case (a)
      3'd0: return m_sw;
      3'd1: return m_led;
      3'd2: return m_mask;
      3'd3: return m_ecap;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sw = '0; m_led = '0; m_mask = '0; m_ecap = '0; m_prev = '0; m_rise = '0;
      h0 = '0; h1 = '0; m_rd = '0; m_rdv = 1'b0; m_irq = 1'b0; m_k = 0;
    end else begin
      m_rd  = bus.avs_read ? {24'h0, reg_val(bus.avs_address)} : 32'h0;
      m_rdv = bus.avs_read;
      m_irq = |(m_ecap & m_mask);
      wdm   = bus.avs_writedata[7:0];
      clr   = (bus.avs_write && bus.avs_address == 3'd3) ? wdm : 8'h00;
      m_ecap = (m_ecap & ~clr) | m_rise;
      if (bus.avs_write) begin
        if (bus.avs_address == 3'd1) m_led = wdm;
        if (bus.avs_address == 3'd2) m_mask = wdm;
        if (bus.avs_address == 3'd4) m_led = m_led | wdm;
        if (bus.avs_address == 3'd5) m_led = m_led & ~wdm;
      end
      samp = h0; h0 = h1; h1 = switch_in;
      m_rise = '0;
      if (m_k % N == N - 1) begin
        for (int i = 0; i < 8; i++) nsw[i] = (samp[i] == m_prev[i]) ? samp[i] : m_sw[i];
        m_rise = nsw & ~m_sw;
        m_sw   = nsw;
        m_prev = samp;
      end
      m_k++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("led_out", 32'(led_out), 32'(m_led));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("readdatavalid", 32'(bus.avs_readdatavalid), 32'(m_rdv));
    chk("readdata", bus.avs_readdata, m_rd);
  end

  // bus tasks start and end on a falling edge
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.avs_write = 1'b1; bus.avs_address = a; bus.avs_writedata = d;
    @(negedge clk);
    bus.avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.avs_read = 1'b1; bus.avs_address = a;
    @(negedge clk);
    bus.avs_read = 1'b0;
    chk("rd_valid", 32'(bus.avs_readdatavalid), 32'd1);
    d = bus.avs_readdata;
  endtask

  typedef struct {
    int          op;
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;

  initial begin
    vec_t        tbl[$];
    logic [31:0] d;
    int          n;
    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    // op 0 = write, 1 = read and compare, 2 = compare led_out
    tbl.push_back('{0, 3'd1, 32'h0000_00A5, 32'h0});
    tbl.push_back('{2, 3'd0, 32'h0, 32'h0000_00A5});
    tbl.push_back('{1, 3'd1, 32'h0, 32'h0000_00A5});
    tbl.push_back('{0, 3'd1, 32'h0000_00F0, 32'h0});
    tbl.push_back('{0, 3'd4, 32'h0000_000F, 32'h0});
    tbl.push_back('{2, 3'd0, 32'h0, 32'h0000_00FF});
    tbl.push_back('{0, 3'd5, 32'h0000_0030, 32'h0});
    tbl.push_back('{2, 3'd0, 32'h0, 32'h0000_00CF});
    tbl.push_back('{1, 3'd4, 32'h0, 32'h0});
    tbl.push_back('{1, 3'd5, 32'h0, 32'h0});
    tbl.push_back('{0, 3'd1, 32'h1234_5677, 32'h0});
    tbl.push_back('{1, 3'd1, 32'h0, 32'h0000_0077});
    tbl.push_back('{0, 3'd2, 32'hFFFF_FF5A, 32'h0});
    tbl.push_back('{1, 3'd2, 32'h0, 32'h0000_005A});
    tbl.push_back('{0, 3'd6, 32'h0000_00FF, 32'h0});
    tbl.push_back('{1, 3'd6, 32'h0, 32'h0});
    tbl.push_back('{1, 3'd7, 32'h0, 32'h0});
    tbl.push_back('{1, 3'd0, 32'h0, 32'h0});
    tbl.push_back('{0, 3'd2, 32'h0, 32'h0});
    repeat (3) @(negedge clk);
    chk("reset_led", 32'(led_out), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    foreach (tbl[i]) begin
      if (tbl[i].op == 0) wr(tbl[i].a, tbl[i].d);
      else if (tbl[i].op == 1) begin rd(tbl[i].a, d); chk($sformatf("vec%0d_rd", i), d, tbl[i].e); end
      else chk($sformatf("vec%0d_led", i), 32'(led_out), tbl[i].e);
    end
    // debounced rising edge, capture and masked irq
    switch_in = 8'h01;
    repeat (20) @(negedge clk);
    rd(3'd0, d); chk("sw_data_01", d, 32'h01);
    rd(3'd3, d); chk("edge_cap_01", d, 32'h01);
    wr(3'd2, 32'h01);
    repeat (2) @(negedge clk);
    chk("irq_set", 32'(irq), 32'h1);
    wr(3'd3, 32'h01);
    chk("irq_still", 32'(irq), 32'h1);
    @(negedge clk);
    chk("irq_clr", 32'(irq), 32'h0);
    // bit2 chatters every 2 clocks, low whenever the sampler looks
    for (int i = 0; i < 40; i++) begin
      switch_in = 8'h01 | ((m_k % N == 0 || m_k % N == 3) ? 8'h04 : 8'h00);
      @(negedge clk);
    end
    switch_in = 8'h01;
    rd(3'd0, d); chk("chatter_sw", d, 32'h01);
    rd(3'd3, d); chk("chatter_ecap", d, 32'h00);
    // rising edge collides with W1C of the same bit
    switch_in = 8'h00;
    repeat (20) @(negedge clk);
    rd(3'd0, d); chk("sw_low", d, 32'h00);
    switch_in = 8'h01;
    n = 0;
    while (!m_rise[0] && n < 100) begin @(negedge clk); n++; end
    chk("rise_seen", 32'(n < 100), 32'h1);
    wr(3'd3, 32'h01);
    rd(3'd3, d); chk("collide_ecap", d, 32'h01);
    repeat (2) @(negedge clk);
    chk("collide_irq", 32'(irq), 32'h1);
    // random traffic checked every cycle against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) switch_in = 8'($urandom);
      bus.avs_read      = $urandom_range(0, 2) == 0;
      bus.avs_write     = $urandom_range(0, 3) == 0;
      bus.avs_address   = 3'($urandom);
      bus.avs_writedata = $urandom;
      @(negedge clk);
    end
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    // reset in the middle of a read
    wr(3'd1, 32'h55);
    chk("led_55", 32'(led_out), 32'h55);
    bus.avs_read = 1'b1; bus.avs_address = 3'd1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_rdv", 32'(bus.avs_readdatavalid), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    bus.avs_read = 1'b0;
    chk("rst_hold_rdv", 32'(bus.avs_readdatavalid), 32'h0);
    #2 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_rdv", 32'(bus.avs_readdatavalid), 32'h0);
    end
    rd(3'd1, d); chk("post_rst_led", d, 32'h0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
